// File: rtl/port_pkg.sv
// port_pkg: definitions shared by the switch port ingress and egress blocks.
// Control frame layout, egress FSM states and the length-to-words helper.
package port_pkg;

    localparam int DEST_LSB  = 0;
    localparam int DEST_W    = 4;
    localparam int PRIOR_LSB = 4;
    localparam int PRIOR_W   = 3;
    localparam int LEN_LSB   = 7;
    localparam int LEN_W     = 9;

    typedef enum logic [2:0] {
        IDLE,
        SOP,
        CTRL,
        DATA,
        EOP,
        GAP
    } tx_state_t;

    typedef struct packed {
        logic [LEN_W-1:0]   len;
        logic [PRIOR_W-1:0] prior;
        logic [DEST_W-1:0]  dest;
    } ctrl_t;

    // Bytes to 16-bit words, rounding up; 511 bytes -> 256 words.
    function automatic logic [LEN_W-1:0] words_from_len(
        input logic [LEN_W-1:0] len
    );
        logic [LEN_W:0] sum;
        sum = {1'b0, len} + {{LEN_W{1'b0}}, 1'b1};
        return sum[LEN_W:1];
    endfunction

endpackage

// File: rtl/port_tx_if.sv
// port_tx_if: queue read path and device-side packet stream of an egress port.
// master = the egress port, slave = queue plus external device.
interface port_tx_if #(
    parameter int DW = 16
);
    logic          ready;
    logic          q_pkt_avail;
    logic          q_empty;
    logic          q_rd;
    logic [DW-1:0] q_dout;
    logic          rd_sop;
    logic          rd_vld;
    logic [DW-1:0] rd_data;
    logic          rd_eop;

    modport master (
        input  ready,
        input  q_pkt_avail,
        input  q_empty,
        input  q_dout,
        output q_rd,
        output rd_sop,
        output rd_vld,
        output rd_data,
        output rd_eop
    );

    modport slave (
        output ready,
        output q_pkt_avail,
        output q_empty,
        output q_dout,
        input  q_rd,
        input  rd_sop,
        input  rd_vld,
        input  rd_data,
        input  rd_eop
    );
endinterface

// File: rtl/port_tx.sv
// port_tx: egress side of a switch port.
// Pops one queued packet and streams rd_sop, control frame, data, rd_eop.
module port_tx #(
    parameter int DW      = 16,
    parameter int LEN_LSB = port_pkg::LEN_LSB,
    parameter int LEN_W   = port_pkg::LEN_W
) (
    input  logic                      clk,
    input  logic                      rst,
    port_tx_if.master                 bus,
    output logic                      busy,
    output logic [port_pkg::PRIOR_W-1:0] tx_prior,
    output logic [LEN_W-1:0]          tx_len,
    output logic                      pkt_done
);
    import port_pkg::*;

    tx_state_t        state;
    tx_state_t        state_n;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_n;
    logic [LEN_W-1:0] len_f;
    logic [LEN_W:0]   len_p1;
    logic [LEN_W-1:0] words;
    logic             pop;
    logic             pop_d;
    logic             sop_q;
    logic             vld_q;
    logic             eop_q;
    logic [DW-1:0]    data_q;

    assign len_f  = bus.q_dout[LEN_LSB +: LEN_W];
    assign len_p1 = {1'b0, len_f} + {{LEN_W{1'b0}}, 1'b1};
    assign words  = len_p1[LEN_W:1];

    // cnt holds the data pops still owed for the current packet.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.ready && bus.q_pkt_avail) begin
                    state_n = SOP;
                end
            end
            SOP: begin
                pop     = 1'b1;
                state_n = CTRL;
            end
            CTRL: begin
                pop     = (words != '0) && !bus.q_empty;
                cnt_n   = words - {{(LEN_W-1){1'b0}}, pop};
                state_n = (words != '0) ? DATA : EOP;
            end
            DATA: begin
                if (cnt == '0) begin
                    state_n = EOP;
                end else if (!bus.q_empty) begin
                    pop   = 1'b1;
                    cnt_n = cnt - LEN_W'(1);
                end
            end
            EOP: begin
                state_n = GAP;
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // A word popped in one cycle is on q_dout the next and on rd_data after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pop_d    <= 1'b0;
            sop_q    <= 1'b0;
            vld_q    <= 1'b0;
            eop_q    <= 1'b0;
            data_q   <= '0;
            busy     <= 1'b0;
            pkt_done <= 1'b0;
            tx_prior <= '0;
            tx_len   <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pop_d    <= pop;
            sop_q    <= (state_n == SOP);
            vld_q    <= pop_d;
            eop_q    <= (state == EOP);
            pkt_done <= (state == EOP);
            busy     <= (state_n != IDLE);
            if (pop_d) begin
                data_q <= bus.q_dout;
            end
            if (state == CTRL) begin
                tx_prior <= bus.q_dout[PRIOR_LSB +: PRIOR_W];
                tx_len   <= len_f;
            end
        end
    end

    assign bus.q_rd    = pop;
    assign bus.rd_sop  = sop_q;
    assign bus.rd_vld  = vld_q;
    assign bus.rd_data = data_q;
    assign bus.rd_eop  = eop_q;

endmodule

// File: doc/port_tx.md
Name: port_tx

Overview:
- Egress side of a switch port, the transmit counterpart of the ingress port that accepts wr_sop/wr_vld/wr_data/wr_eop.
- Pulls one stored packet from its per-port output queue and serialises it to the external device as rd_sop, control frame, data words, rd_eop.
- The first word of every packet is the control frame, in the same format the ingress port decodes: [3:0] dest_port, [6:4] prior, [15:7] byte length.
- Sits between the output queue/SRAM read path and the device pins; packet scheduling happens upstream.

Parameters:
- DW, 16: data word width.
- LEN_LSB, 7: bit offset of the length field in the control frame.
- LEN_W, 9: width of the length field (bytes).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- ready  in  1  device can accept a whole packet; sampled only in IDLE.
- q_pkt_avail  in  1  queue holds at least one complete packet.
- q_empty  in  1  queue word FIFO empty.
- q_rd  out  1  pop request; data returns on q_dout in the next cycle.
- q_dout  in  DW  queue read data, valid the cycle after q_rd.
- rd_sop  out  1  start-of-packet pulse.
- rd_vld  out  1  rd_data qualifier.
- rd_data  out  DW  packet word (control frame first).
- rd_eop  out  1  end-of-packet pulse.
- busy  out  1  high from rd_sop through rd_eop inclusive.
- tx_prior  out  3  prior of the current packet, latched from the control frame.
- tx_len  out  LEN_W  byte length of the current packet, latched from the control frame.
- pkt_done  out  1  pulse coincident with rd_eop.

Behaviour:
- Reset:
  - All outputs 0; FSM in IDLE; word counter 0.
  - Reset mid-packet aborts with no rd_eop. The queue shares rst, so no partial packet survives.
- States:
  - IDLE: if ready & q_pkt_avail, go to SOP.
  - SOP: rd_sop=1, q_rd=1 (pop control frame), then go to CTRL.
  - CTRL: q_dout holds the control frame.
    - Word count W = (len+1)>>1, computed from q_dout[LEN_LSB+:LEN_W].
    - Load the counter with W. Latch tx_prior and tx_len. Register q_dout onto rd_data.
    - Assert q_rd if W>0 & !q_empty.
    - Go to DATA if W>0, else to EOP.
  - DATA: each cycle with counter>0 & !q_empty, assert q_rd and decrement. The word returned one cycle later is registered to rd_data with rd_vld=1. Go to EOP once the last popped word has been output.
  - EOP: rd_eop=1, pkt_done=1, rd_vld=0, then go to GAP.
  - GAP: one idle cycle, then IDLE.
- Timing, no underflow, rd_sop at cycle S:
  - S+1: gap, rd_vld=0.
  - S+2: control frame on rd_data, rd_vld=1.
  - S+3 .. S+2+W: data words, contiguous.
  - S+3+W: rd_eop.
  - Earliest next rd_sop: S+5+W.
- Underflow: if q_empty while counter>0, no pop is issued. rd_vld is 0 in the corresponding output cycle (a bubble); the counter holds and transmission resumes when q_empty drops. rd_data holds its last value during bubbles.
- rd_sop, rd_eop and rd_vld are never high in the same cycle.
- ready is ignored once a packet starts: a committed packet always completes.
- len=0: control frame only, no data pops, rd_eop at S+3.
- Odd len: the final word is sent whole; padding content is passed through unchanged.
- Width rules:
  - Counter width is LEN_W bits (max W=256).
  - Max len 511 gives W=256; the counter must hold 256 without wrap.
- All outputs are registered; q_rd is driven from state and counter registers plus q_empty.

Decomposition:
- Shared package port_pkg holds:
  - ctrl-frame field offsets and widths (DEST_LSB=0/4, PRIOR_LSB=4/3, LEN_LSB=7/9);
  - the FSM state enum (IDLE, SOP, CTRL, DATA, EOP, GAP);
  - a words_from_len function.
- The ingress port imports the same package.
- No sub-module is natural: a single FSM plus a counter and an output register.

Test Plan:
- ctrl 0x0082 (len 1, W=1), data 0xBEEF, ready=1 -> rd_sop at S; rd_data=0x0082 vld at S+2; 0xBEEF at S+3; rd_eop at S+4; tx_len=1, tx_prior=0.
- ctrl 0x1E92 (len 61, W=31, prior 1, dest 2) -> exactly 32 vld words; rd_eop at S+34; 32 q_rd pulses total; tx_prior=1.
- ctrl 0x0005 (len 0) -> rd_data=0x0005 at S+2 only; rd_eop at S+3; exactly one q_rd.
- q_empty forced high for 3 cycles at the 5th data word of a W=8 packet -> 3 rd_vld=0 bubbles; words in order; rd_eop delayed by 3 cycles.
- ready=0 with q_pkt_avail=1 -> no rd_sop; ready rises -> rd_sop next cycle. Drop ready mid-packet -> packet still completes.
- Assert rst at the 4th data word -> all outputs 0 next edge; no rd_eop; next packet after release starts cleanly at rd_sop.
